keypad_scan_fifo: RTL

KEYPAD_SCAN_FIFO -- requirements
Module: keypad_scan_fifo

---
 rtl/keypad_scan_fifo.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_fifo.sv
// rtl/keypad_scan_fifo.sv - row-scanned keypad with debounce, key-code FIFO and interrupt flags
module keypad_scan_fifo #(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int SCAN_DIV = 20000,
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 4,
  localparam int KW      = $clog2(ROWS*COLS)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [COLS-1:0] COL_IN,
  output logic [ROWS-1:0] ROW_OUT,
  output logic [KW-1:0]   KEY_CODE,
  output logic            KEY_VALID,
  input  logic            KEY_RD,
  output logic            INTR,
  input  logic            INTR_ACK,
  output logic            OVERFLOW
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  state_t        state;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [RW-1:0] row_idx;
  logic [RW-1:0] row_next;
  logic [CW-1:0] lat_col;
  logic [CW-1:0] lo_col;
  logic          col_any;
  logic          same_col;
  logic [DW-1:0] db_cnt;
  logic [DW-1:0] db_next;
  logic          db_done;
  logic          push;
  logic [KW-1:0] push_code;

  assign tick = (pre_cnt == PW'(SCAN_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST) pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + 1'b1;
  end

  // Lowest set column wins when several keys share the driven row
  always_comb begin
    lo_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (COL_IN[i]) lo_col = CW'(i);
    end
  end

  assign col_any   = |COL_IN;
  assign same_col  = col_any && (lo_col == lat_col);
  assign row_next  = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
  assign db_next   = db_cnt + 1'b1;
  assign db_done   = (db_next == DW'(DEBOUNCE));
  // The row stays held from latch to push, so the live row index is the key's row
  assign push_code = KW'(row_idx) * KW'(COLS) + KW'(lo_col);

  always_comb begin
    push = 1'b0;
    if (tick) begin
      if (state == S_SCAN && col_any && DEBOUNCE == 1) push = 1'b1;
      if (state == S_DEBOUNCE && same_col && db_done) push = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_SCAN;
      row_idx <= '0;
      ROW_OUT <= ROWS'(1);
      lat_col <= '0;
      db_cnt  <= '0;
    end else if (tick) begin
      case (state)
        S_SCAN: begin
          if (col_any) begin
            lat_col <= lo_col;
            db_cnt  <= DW'(1);
            state   <= (DEBOUNCE == 1) ? S_HELD : S_DEBOUNCE;
          end else begin
            row_idx <= row_next;
            ROW_OUT <= ROWS'(1) << row_next;
          end
        end
        S_DEBOUNCE: begin
          if (same_col) begin
            db_cnt <= db_next;
            if (db_done) state <= S_HELD;
          end else begin
            state   <= S_SCAN;
            row_idx <= row_next;
            ROW_OUT <= ROWS'(1) << row_next;
          end
        end
        S_HELD: begin
          if (!col_any) begin
            if (DEBOUNCE == 1) begin
              state   <= S_SCAN;
              row_idx <= row_next;
              ROW_OUT <= ROWS'(1) << row_next;
            end else begin
              state  <= S_RELEASE;
              db_cnt <= DW'(1);
            end
          end
        end
        S_RELEASE: begin
          if (col_any) begin
            state <= S_HELD;
          end else begin
            db_cnt <= db_next;
            if (db_done) begin
              state   <= S_SCAN;
              row_idx <= row_next;
              ROW_OUT <= ROWS'(1) << row_next;
            end
          end
        end
        default: state <= S_SCAN;
      endcase
    end
  end

  logic [KW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign full      = (count == DEPTH_C);
  assign KEY_VALID = (count != '0);
  assign pop       = KEY_RD && KEY_VALID;
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign KEY_CODE  = KEY_VALID ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A push attempt in the same cycle as the acknowledge keeps the flags set
  always_ff @(posedge CLK) begin
    if (RST) begin
      INTR     <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) INTR <= 1'b1;
      else if (INTR_ACK) INTR <= 1'b0;
      if (drop) OVERFLOW <= 1'b1;
      else if (INTR_ACK) OVERFLOW <= 1'b0;
    end
  end

endmodule
